// File: rtl/mem_wr_ctrl_pp.sv
// Raster pixel stream to two-region (ping-pong) BRAM writer with per-buffer ready/ack handoff.
// One-cycle write latency; no backpressure: full buffers cause whole frames to be dropped.
module mem_wr_ctrl_pp #(
  parameter int DATA_W  = 8,
  parameter int MAX_ROW = 360,
  parameter int MAX_COL = 540,
  parameter int ADDR_W  = 19,
  localparam int ROW_W  = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1,
  localparam int COL_W  = (MAX_COL > 1) ? $clog2(MAX_COL) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              pixel_en_i,
  input  logic              sof_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] d2mema_o,
  output logic [1:0]        buf_rdy_o,
  input  logic [1:0]        ack_i,
  output logic              frame_done_o,
  output logic              done_buf_o,
  output logic              wr_buf_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic              overflow_o,
  output logic              sync_err_o
);

  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(MAX_ROW * MAX_COL);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MAX_ROW - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(MAX_COL - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cur_q, cur_d;
  logic                wr_buf_q, wr_buf_d;
  logic [1:0]          rdy_q, rdy_d, rdy_set;
  logic                ena_q, ena_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                done_q, done_d;
  logic                dbuf_q, dbuf_d;
  logic                ovf_q, ovf_d;
  logic                serr_q, serr_d;

  // Per-pixel working values: position and address of the pixel accepted this cycle
  logic                tgt;
  logic                wr_px;
  logic                cnt_px;
  logic [ROW_W-1:0]    r;
  logic [COL_W-1:0]    c;
  logic [ADDR_W-1:0]   a;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    cur_d    = cur_q;
    wr_buf_d = wr_buf_q;
    rdy_set  = 2'b00;
    ena_d    = 1'b0;
    addra_d  = '0;
    dat_d    = '0;
    done_d   = 1'b0;
    dbuf_d   = 1'b0;
    ovf_d    = ovf_q;
    serr_d   = serr_q;
    tgt      = cur_q;
    wr_px    = 1'b0;
    cnt_px   = 1'b0;
    r        = row_q;
    c        = col_q;
    a        = addr_q;

    if (pixel_en_i) begin
      if (sof_i) begin
        r      = '0;
        c      = '0;
        cnt_px = 1'b1;
        if (state_q != IDLE) serr_d = 1'b1;
        // A restart inside WRITE reuses the buffer it already owns
        if (state_q == WRITE) begin
          tgt   = cur_q;
          wr_px = 1'b1;
        end else if (!rdy_q[wr_buf_q]) begin
          tgt   = wr_buf_q;
          wr_px = 1'b1;
        end else if (!rdy_q[~wr_buf_q]) begin
          tgt      = ~wr_buf_q;
          wr_buf_d = ~wr_buf_q;
          wr_px    = 1'b1;
        end else begin
          ovf_d   = 1'b1;
          state_d = DROP;
        end
        a = tgt ? BASE1 : '0;
        if (wr_px) begin
          state_d = WRITE;
          cur_d   = tgt;
        end
      end else begin
        wr_px  = (state_q == WRITE);
        cnt_px = (state_q != IDLE);
      end
    end

    if (wr_px) begin
      ena_d   = 1'b1;
      addra_d = a;
      dat_d   = pixel_i;
      addr_d  = a + ADDR_W'(1);
    end

    if (cnt_px) begin
      if (r == ROW_LAST && c == COL_LAST) begin
        row_d   = '0;
        col_d   = '0;
        state_d = IDLE;
        if (wr_px) begin
          done_d       = 1'b1;
          dbuf_d       = tgt;
          rdy_set[tgt] = 1'b1;
          wr_buf_d     = ~tgt;
        end
      end else if (c == COL_LAST) begin
        col_d = '0;
        row_d = r + ROW_W'(1);
      end else begin
        row_d = r;
        col_d = c + COL_W'(1);
      end
    end

    // A completing frame outranks a same-cycle ack of that buffer
    rdy_d = (rdy_q & ~ack_i) | rdy_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      cur_q    <= 1'b0;
      wr_buf_q <= 1'b0;
      rdy_q    <= 2'b00;
      ena_q    <= 1'b0;
      addra_q  <= '0;
      dat_q    <= '0;
      done_q   <= 1'b0;
      dbuf_q   <= 1'b0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      cur_q    <= cur_d;
      wr_buf_q <= wr_buf_d;
      rdy_q    <= rdy_d;
      ena_q    <= ena_d;
      addra_q  <= addra_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      dbuf_q   <= dbuf_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
    end
  end

  assign ena_o        = ena_q;
  assign wea_o        = ena_q;
  assign addra_o      = addra_q;
  assign d2mema_o     = dat_q;
  assign buf_rdy_o    = rdy_q;
  assign frame_done_o = done_q;
  assign done_buf_o   = dbuf_q;
  assign wr_buf_o     = wr_buf_q;
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign overflow_o   = ovf_q;
  assign sync_err_o   = serr_q;

endmodule

// File: tb/tb_mem_wr_ctrl_pp.sv
// Bench for mem_wr_ctrl_pp: frame-level reference model checked every cycle plus literal frame checks.
module tb_mem_wr_ctrl_pp;
  localparam int DATA_W  = 8;
  localparam int MAX_ROW = 2;
  localparam int MAX_COL = 3;
  localparam int ADDR_W  = 4;
  localparam int FRAME   = MAX_ROW * MAX_COL;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] pixel_i = '0;
  logic              pixel_en_i = 1'b0;
  logic              sof_i = 1'b0;
  logic [1:0]        ack_i = 2'b00;
  logic              ena_o, wea_o, frame_done_o, done_buf_o, wr_buf_o, overflow_o, sync_err_o;
  logic [ADDR_W-1:0] addra_o;
  logic [DATA_W-1:0] d2mema_o;
  logic [1:0]        buf_rdy_o;
  logic [0:0]        row_o;
  logic [1:0]        col_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wr_ctrl_pp #(.DATA_W(DATA_W), .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i), .sof_i(sof_i),
    .ena_o(ena_o), .wea_o(wea_o), .addra_o(addra_o), .d2mema_o(d2mema_o),
    .buf_rdy_o(buf_rdy_o), .ack_i(ack_i), .frame_done_o(frame_done_o),
    .done_buf_o(done_buf_o), .wr_buf_o(wr_buf_o), .row_o(row_o), .col_o(col_o),
    .overflow_o(overflow_o), .sync_err_o(sync_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 writing, 2 dropping; pos is the linear pixel index in the frame
  int       m_mode, m_pos, m_buf, t;
  bit       m_wr, m_ovf, m_serr, cmp_on;
  bit [1:0] m_rdy, setb;
  int       e_ena, e_addr, e_data, e_done, e_dbuf;

  always @(posedge clk) begin
    cmp_on = 1'b1;
    e_ena = 0; e_addr = 0; e_data = 0; e_done = 0; e_dbuf = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_buf = 0; m_wr = 0; m_rdy = 0; m_ovf = 0; m_serr = 0;
    end else begin
      setb = 2'b00;
      if (pixel_en_i) begin
        if (sof_i) begin
          if (m_mode != 0) m_serr = 1;
          if (m_mode == 1) t = m_buf;
          else if (!m_rdy[m_wr]) t = int'(m_wr);
          else if (!m_rdy[!m_wr]) begin t = int'(!m_wr); m_wr = !m_wr; end
          else t = -1;
          m_pos = 0;
          if (t < 0) begin m_mode = 2; m_ovf = 1; end
          else begin m_mode = 1; m_buf = t; end
        end
        if (m_mode == 1) begin
          e_ena = 1; e_addr = m_buf * FRAME + m_pos; e_data = int'(pixel_i);
        end
        if (m_mode != 0) begin
          if (m_pos == FRAME - 1) begin
            if (m_mode == 1) begin
              e_done = 1; e_dbuf = m_buf; setb[m_buf] = 1'b1; m_wr = (m_buf == 0);
            end
            m_mode = 0; m_pos = 0;
          end else begin
            m_pos++;
          end
        end
      end
      m_rdy = (m_rdy & ~ack_i) | setb;
    end
  end

  int cap_a[$], cap_d[$], cap_b[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_ena", 32'(ena_o), 32'(e_ena));
      check("cyc_wea", 32'(wea_o), 32'(e_ena));
      check("cyc_addr", 32'(addra_o), 32'(e_addr));
      check("cyc_data", 32'(d2mema_o), 32'(e_data));
      check("cyc_done", 32'(frame_done_o), 32'(e_done));
      check("cyc_dbuf", 32'(done_buf_o), 32'(e_dbuf));
      check("cyc_rdy", 32'(buf_rdy_o), 32'(m_rdy));
      check("cyc_wrbuf", 32'(wr_buf_o), 32'(m_wr));
      check("cyc_row", 32'(row_o), 32'(m_pos / MAX_COL));
      check("cyc_col", 32'(col_o), 32'(m_pos % MAX_COL));
      check("cyc_ovf", 32'(overflow_o), 32'(m_ovf));
      check("cyc_serr", 32'(sync_err_o), 32'(m_serr));
      if (ena_o === 1'b1) begin
        cap_a.push_back(int'(addra_o));
        cap_d.push_back(int'(d2mema_o));
      end
      if (frame_done_o === 1'b1) cap_b.push_back(int'(done_buf_o));
    end
  end

  task automatic clear_cap();
    cap_a.delete(); cap_d.delete(); cap_b.delete();
  endtask

  task automatic send(input int d, input bit s);
    pixel_i = DATA_W'(d); pixel_en_i = 1'b1; sof_i = s;
    @(posedge clk); #1;
    pixel_en_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_ack(input logic [1:0] a);
    ack_i = a;
    @(posedge clk); #1;
    ack_i = 2'b00;
  endtask

  task automatic send_frame(input int d0);
    send(d0, 1'b1);
    for (int i = 1; i < FRAME; i++) send(d0 + i, 1'b0);
    idle(2);
  endtask

  task automatic check_frame(input string tag, input int a0, input int d0, input int n);
    check({tag, "_nwr"}, 32'(cap_a.size()), 32'(n));
    for (int i = 0; i < n && i < cap_a.size(); i++) begin
      check({tag, "_addr"}, 32'(cap_a[i]), 32'(a0 + i));
      check({tag, "_data"}, 32'(cap_d[i]), 32'(d0 + i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[10];
    int ed[10];
    ea = '{6, 7, 8, 9, 6, 7, 8, 9, 10, 11};
    ed = '{1, 2, 3, 4, 9, 10, 11, 12, 13, 14};

    rst = 1'b1;
    idle(2);
    check("reset_ena", 32'(ena_o), 32'd0);
    check("reset_rdy", 32'(buf_rdy_o), 32'd0);
    check("reset_flags", 32'({overflow_o, sync_err_o, wr_buf_o}), 32'd0);
    rst = 1'b0;
    idle(1);

    clear_cap();
    send_frame(1);
    check_frame("f1", 0, 1, 6);
    check("f1_done_cnt", 32'(cap_b.size()), 32'd1);
    if (cap_b.size() > 0) check("f1_done_buf", 32'(cap_b[0]), 32'd0);
    check("f1_rdy", 32'(buf_rdy_o), 32'b01);
    check("f1_wrbuf", 32'(wr_buf_o), 32'd1);
    check("f1_model_rdy", 32'(m_rdy), 32'b01);

    clear_cap();
    send_frame(7);
    check_frame("f2", 6, 7, 6);
    if (cap_b.size() > 0) check("f2_done_buf", 32'(cap_b[0]), 32'd1);
    check("f2_rdy", 32'(buf_rdy_o), 32'b11);
    check("f2_model_wr", 32'(m_wr), 32'd0);

    clear_cap();
    send_frame(13);
    check("f3_nwr", 32'(cap_a.size()), 32'd0);
    check("f3_ovf", 32'(overflow_o), 32'd1);
    check("f3_rowcol", 32'({row_o, col_o}), 32'd0);
    do_ack(2'b01);
    check("f3_ack_rdy", 32'(buf_rdy_o), 32'b10);
    clear_cap();
    send_frame(20);
    check_frame("f4", 0, 20, 6);
    check("f4_rdy", 32'(buf_rdy_o), 32'b11);

    do_ack(2'b11);
    clear_cap();
    send(1, 1'b1); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
    send(9, 1'b1);
    for (int i = 10; i < 15; i++) send(i, 1'b0);
    idle(2);
    check("sync_nwr", 32'(cap_a.size()), 32'd10);
    for (int i = 0; i < 10 && i < cap_a.size(); i++) begin
      check("sync_addr", 32'(cap_a[i]), 32'(ea[i]));
      check("sync_data", 32'(cap_d[i]), 32'(ed[i]));
    end
    check("sync_err", 32'(sync_err_o), 32'd1);
    check("sync_done_cnt", 32'(cap_b.size()), 32'd1);
    check("sync_rdy", 32'(buf_rdy_o), 32'b10);

    clear_cap();
    send(70, 1'b0); send(71, 1'b0); send(72, 1'b0);
    idle(1);
    check("idle_nosof_nwr", 32'(cap_a.size()), 32'd0);
    send(30, 1'b1);
    for (int i = 31; i < 36; i++) begin idle(1); send(i, 1'b0); end
    idle(2);
    check_frame("gap", 0, 30, 6);
    check("gap_rdy", 32'(buf_rdy_o), 32'b11);

    do_ack(2'b11);
    send(40, 1'b1); send(41, 1'b0); send(42, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outputs", 32'({ena_o, wea_o, addra_o, d2mema_o, buf_rdy_o, frame_done_o,
                              done_buf_o, wr_buf_o, row_o, col_o, overflow_o, sync_err_o}), 32'd0);
    rst = 1'b0;
    idle(1);
    clear_cap();
    send(50, 1'b0);
    send_frame(60);
    check_frame("rst_f", 0, 60, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wr_ctrl_pp.md
# mem_wr_ctrl_pp

Parametrised pixel-stream-to-BRAM write controller with ping-pong double buffering. Accepts a raster pixel stream with start-of-frame marking, writes each frame into one of two frame regions of a single BRAM port, and hands completed frames to a downstream reader through a per-buffer ready/acknowledge handshake. Sits between the pixel source and the frame BRAM, replacing the single-region free-running address counter used so far.

## Interface
- DATA_W, 8, pixel and BRAM data width
- MAX_ROW, 360, rows per frame
- MAX_COL, 540, pixels per row
- ADDR_W, 19, BRAM address width; 2*MAX_ROW*MAX_COL <= 2^ADDR_W is required

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- pixel_i  in  DATA_W  pixel data, qualified by pixel_en_i
- pixel_en_i  in  1  pixel valid; a pixel is accepted every cycle this is high (no backpressure)
- sof_i  in  1  marks the accepted pixel as first of a frame; ignored when pixel_en_i is low
- ena_o  out  1  BRAM enable
- wea_o  out  1  BRAM write enable (always equals ena_o)
- addra_o  out  ADDR_W  BRAM address
- d2mema_o  out  DATA_W  BRAM write data; 0 when ena_o is low
- buf_rdy_o  out  2  bit b is high while buffer b holds a complete, unconsumed frame
- ack_i  in  2  reader releases buffer b (single-cycle pulse per bit)
- frame_done_o  out  1  one-cycle pulse on the last write of a frame
- done_buf_o  out  1  buffer index completed; valid with frame_done_o
- wr_buf_o  out  1  buffer currently targeted (preferred) for writing
- row_o  out  clog2(MAX_ROW)  row of the next expected pixel
- col_o  out  clog2(MAX_COL)  column of the next expected pixel
- overflow_o  out  1  sticky: a frame was dropped because both buffers were full
- sync_err_o  out  1  sticky: sof_i arrived before a frame completed

## Operation
- FRAME = MAX_ROW*MAX_COL; base(b) = b*FRAME; write address = base + row*MAX_COL + col (kept as an incrementing linear counter, never a multiplier).
- States: IDLE, WRITE, DROP.
- IDLE: accepted pixels without sof_i are discarded (no BRAM access, counters stay 0). On accepted sof_i, target selection runs: wr_buf if buf_rdy[wr_buf]=0, else the other buffer if free (wr_buf updated to it), else DROP with overflow_o set. In WRITE the sof pixel is written at offset 0 and col advances to 1.
- WRITE: each accepted pixel is written, then col increments; col wraps MAX_COL-1 -> 0 and row increments. On the pixel at (MAX_ROW-1, MAX_COL-1): write it, pulse frame_done_o, set buf_rdy[buf], done_buf_o = buf, toggle wr_buf, clear row/col, go to IDLE.
- sof_i accepted in WRITE: set sync_err_o, abandon the partial frame (buf_rdy unchanged), write this pixel at offset 0 of the same buffer, remain in WRITE.
- DROP: pixels are counted with row/col but not written; after the last pixel go to IDLE. sof_i in DROP reruns target selection (sync_err_o set).
- ack_i[b] clears buf_rdy[b]; ack of a non-ready buffer is ignored. If set and ack hit the same bit in one cycle, set wins.
- A buffer with buf_rdy=1 is never written.

## Timing
- Reset: ena_o, wea_o, addra_o, d2mema_o, buf_rdy_o, frame_done_o, done_buf_o, wr_buf_o, row_o, col_o, overflow_o, sync_err_o are all 0; state IDLE. Sticky flags clear only on rst.
- Write latency is 1: a pixel accepted in cycle N yields ena_o/wea_o/addra_o/d2mema_o in cycle N+1 for exactly one cycle. Back-to-back pixels give back-to-back writes.
- frame_done_o, done_buf_o and the buf_rdy_o set appear in cycle N+1, coincident with the last write; wr_buf_o toggles in N+1.
- row_o/col_o update in N+1. Gaps in pixel_en_i hold all counters.
- Target selection uses buf_rdy as registered at cycle N, so an ack_i in cycle N does not free the buffer for a sof_i in cycle N.
- rst mid-frame: the partial frame is lost, buffers are released, and the next frame requires sof_i.

## Test plan
Small parameters: MAX_ROW=2, MAX_COL=3, ADDR_W=4, DATA_W=8.
- Reset, then sof + pixels 1..6 back-to-back -> writes addr 0..5 data 1..6 one cycle after each pixel; frame_done_o with the 6th write, done_buf_o=0, buf_rdy_o=01, wr_buf_o=1.
- Second frame 7..12 -> addr 6..11; buf_rdy_o=11, done_buf_o=1.
- Third frame with no ack -> no ena_o, overflow_o=1, IDLE after 6 pixels. Then ack_i=01 and a fourth frame 20..25 -> addr 0..5, buf_rdy_o=11.
- Pixels 1..4, then sof with pixel 9 -> sync_err_o=1, pixel 9 written to base addr (0 or 6 for the current buffer), frame completes 5 pixels later; buf_rdy is not set by the abandoned part.
- Pixels without sof in IDLE -> no writes; pixel_en_i toggling 1/0 in a frame -> writes only on accepted pixels, addresses contiguous.
- rst asserted after 3 pixels of frame 1 -> all outputs 0 next cycle; a new sof frame writes addr 0..5.
